// File: rtl/vector_load_unit_if.sv
// Memory read port and vector-register-file write port of the vector load unit.
// The load unit takes the master side; the memory/VRF model takes the slave side.
interface vector_load_unit_if;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        vrf_we;
   logic [3:0]  vrf_vd;
   logic [31:0] vrf_wd0;
   logic [31:0] vrf_wd1;
   logic [31:0] vrf_wd2;
   logic [31:0] vrf_wd3;
   logic [31:0] vrf_wd4;

   modport master (
      output mem_re, mem_addr,
      input  mem_rdata, mem_rvalid,
      output vrf_we, vrf_vd, vrf_wd0, vrf_wd1, vrf_wd2, vrf_wd3, vrf_wd4
   );

   modport slave (
      input  mem_re, mem_addr,
      output mem_rdata, mem_rvalid,
      input  vrf_we, vrf_vd, vrf_wd0, vrf_wd1, vrf_wd2, vrf_wd3, vrf_wd4
   );
endinterface

// File: rtl/vector_load_unit.sv
// Five-element vector load: one read per element, then a single VRF write; 11 cycles with 1-cycle memory.
// Waits indefinitely for mem_rvalid; start ignored while busy. VLOAD_STRIDE_EN adds a runtime stride port.
module vector_load_unit #(
   parameter int ELEM_BYTES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [3:0]  vd,
`ifdef VLOAD_STRIDE_EN
   input  logic [31:0] stride,
`endif
   output logic        busy,
   output logic        done,
   vector_load_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q;
   logic [31:0] base_q;
   logic [3:0]  vd_q;
   logic [31:0] elem_q [4];
   logic [31:0] wd_q   [5];
   logic [3:0]  vrf_vd_q;
   logic [31:0] step;
   logic        accept;
   logic        capture;
   logic        last;

`ifdef VLOAD_STRIDE_EN
   logic [31:0] stride_q;
   assign step = stride_q;
`else
   assign step = 32'(ELEM_BYTES);
`endif

   assign accept  = (state_q == IDLE) && start;
   assign capture = (state_q == WAIT) && bus.mem_rvalid;
   assign last    = (idx_q == 3'd4);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = REQ;
         REQ:     state_d = WAIT;
         WAIT:    if (bus.mem_rvalid) state_d = last ? WRITE : REQ;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q    <= '0;
         base_q   <= '0;
         vd_q     <= '0;
         vrf_vd_q <= '0;
`ifdef VLOAD_STRIDE_EN
         stride_q <= '0;
`endif
         for (int i = 0; i < 4; i++) elem_q[i] <= '0;
         for (int i = 0; i < 5; i++) wd_q[i]   <= '0;
      end else begin
         if (accept) begin
            idx_q  <= '0;
            base_q <= base_addr;
            vd_q   <= vd;
`ifdef VLOAD_STRIDE_EN
            stride_q <= stride;
`endif
         end
         if (capture) begin
            // Output registers load only on the last element so the VRF
            // bus keeps the previous vector for the whole next command.
            if (last) begin
               for (int i = 0; i < 4; i++) wd_q[i] <= elem_q[i];
               wd_q[4]  <= bus.mem_rdata;
               vrf_vd_q <= vd_q;
            end else begin
               elem_q[idx_q[1:0]] <= bus.mem_rdata;
               idx_q              <= idx_q + 3'd1;
            end
         end
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == WRITE);
   assign bus.mem_re   = (state_q == REQ);
   assign bus.mem_addr = (state_q == REQ) ? (base_q + 32'(idx_q) * step) : 32'd0;
   assign bus.vrf_we   = (state_q == WRITE);
   assign bus.vrf_vd   = vrf_vd_q;
   assign bus.vrf_wd0  = wd_q[0];
   assign bus.vrf_wd1  = wd_q[1];
   assign bus.vrf_wd2  = wd_q[2];
   assign bus.vrf_wd3  = wd_q[3];
   assign bus.vrf_wd4  = wd_q[4];

endmodule

// File: tb/tb_vector_load_unit.sv
// Bench for vector_load_unit: table of load commands against a memory responder and a write scoreboard.
// Builds with or without VLOAD_STRIDE_EN; default build uses a fixed 4-byte step.
module tb_vector_load_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic [3:0]  vd;
`ifdef VLOAD_STRIDE_EN
   logic [31:0] stride;
`endif
   logic        busy;
   logic        done;

   vector_load_unit_if bus();

   vector_load_unit #(.ELEM_BYTES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .vd        (vd),
`ifdef VLOAD_STRIDE_EN
      .stride    (stride),
`endif
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [3:0]  vd;
      logic [31:0] stride;
      logic [31:0] data [5];
      int          delay;
      bit          spur;
   } vec_t;

   typedef struct {
      logic [3:0]  vd;
      logic [31:0] d [5];
   } wr_t;

   vec_t        tbl [4];
   logic [31:0] addr_q [$];
   wr_t         wr_q [$];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] wd(input int k);
      case (k)
         0:       return bus.vrf_wd0;
         1:       return bus.vrf_wd1;
         2:       return bus.vrf_wd2;
         3:       return bus.vrf_wd3;
         default: return bus.vrf_wd4;
      endcase
   endfunction

   task automatic run_cmd(input vec_t v);
      int          cyc;
      int          pulses;
      int          t;
      logic [31:0] step;
      logic [31:0] ea;
      logic [31:0] held0;
      logic [3:0]  heldvd;
      wr_t         w;
      wr_t         e;
`ifdef VLOAD_STRIDE_EN
      step = v.stride;
`else
      step = 32'd4;
`endif
      for (int i = 0; i < 5; i++) addr_q.push_back(v.base + 32'(i) * step);
      w.vd = v.vd;
      for (int i = 0; i < 5; i++) w.d[i] = v.data[i];
      wr_q.push_back(w);

      @(negedge clk);
      start     = 1'b1;
      base_addr = v.base;
      vd        = v.vd;
`ifdef VLOAD_STRIDE_EN
      stride    = v.stride;
`endif
      @(negedge clk);
      start     = 1'b0;
      base_addr = 32'hDEAD_0000;
      vd        = ~v.vd;
`ifdef VLOAD_STRIDE_EN
      stride    = 32'h0000_0100;
`endif
      cyc    = 1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         t = 0;
         while (bus.mem_re !== 1'b1 && t < 50) begin
            @(negedge clk);
            cyc++;
            t++;
         end
         chk("mem_re_seen", 32'(bus.mem_re), 32'd1);
         pulses++;
         ea = addr_q.pop_front();
         chk("mem_addr", bus.mem_addr, ea);
         if (v.spur && i == 1) begin
            start     = 1'b1;
            base_addr = 32'h0000_9990;
            vd        = 4'd1;
         end
         if (v.spur && i == 2) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hBAD0_BAD0;
         end
         @(negedge clk);
         cyc++;
         start          = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (bus.mem_re) pulses++;
         repeat (v.delay) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_re) pulses++;
         end
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = v.data[i];
         @(negedge clk);
         cyc++;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = 32'h0;
      end

      chk("write_cycle", 32'(cyc), 32'(11 + 5 * v.delay));
      chk("vrf_we", 32'(bus.vrf_we), 32'd1);
      chk("done", 32'(done), 32'd1);
      chk("busy_in_write", 32'(busy), 32'd1);
      e = wr_q.pop_front();
      chk("vrf_vd", 32'(bus.vrf_vd), 32'(e.vd));
      for (int k = 0; k < 5; k++) chk("vrf_wd", wd(k), e.d[k]);
      held0  = bus.vrf_wd0;
      heldvd = bus.vrf_vd;

      start     = 1'b1;
      base_addr = 32'h0000_5550;
      @(negedge clk);
      start = 1'b0;
      if (bus.mem_re) pulses++;
      chk("vrf_we_pulse", 32'(bus.vrf_we), 32'd0);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("vrf_wd0_hold", bus.vrf_wd0, held0);
      chk("vrf_vd_hold", 32'(bus.vrf_vd), 32'(heldvd));
      @(negedge clk);
      if (bus.mem_re) pulses++;
      chk("start_in_write_ignored", 32'(busy), 32'd0);
      chk("mem_re_pulses", 32'(pulses), 32'd5);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      bit saw_we;

      tbl[0] = '{base: 32'h0000_0100, vd: 4'd3, stride: 32'd4,
                 data: '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4}, delay: 0, spur: 1'b0};
      tbl[1] = '{base: 32'hFFFF_FFF8, vd: 4'd7, stride: 32'd8,
                 data: '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004},
                 delay: 0, spur: 1'b0};
      tbl[2] = '{base: 32'h0000_2000, vd: 4'd9, stride: 32'hFFFF_FFF0,
                 data: '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004},
                 delay: 3, spur: 1'b0};
      tbl[3] = '{base: 32'h0000_0040, vd: 4'd15, stride: 32'd12,
                 data: '{32'h0BAD_F00D, 32'h1234_5678, 32'h8765_4321, 32'hFFFF_FFFF, 32'h0000_0001},
                 delay: 1, spur: 1'b1};

      reset          = 1'b1;
      start          = 1'b0;
      base_addr      = 32'h0;
      vd             = 4'd0;
`ifdef VLOAD_STRIDE_EN
      stride         = 32'h0;
`endif
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_vrf_we", 32'(bus.vrf_we), 32'd0);
      chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_vrf_vd", 32'(bus.vrf_vd), 32'd0);
      for (int k = 0; k < 5; k++) chk("rst_vrf_wd", wd(k), 32'd0);

      for (int n = 0; n < 4; n++) run_cmd(tbl[n]);

      // Abort after the third element has been captured.
      @(negedge clk);
      start     = 1'b1;
      base_addr = 32'h0000_0300;
      vd        = 4'd5;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         t = 0;
         while (bus.mem_re !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("abort_mem_re", 32'(bus.mem_re), 32'd1);
         @(negedge clk);
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'h77 + 32'(i);
         @(negedge clk);
         bus.mem_rvalid = 1'b0;
      end
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_mem_re_low", 32'(bus.mem_re), 32'd0);
      chk("abort_vrf_wd0", bus.vrf_wd0, 32'd0);
      chk("abort_vrf_vd", 32'(bus.vrf_vd), 32'd0);
      @(negedge clk);
      reset          = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5A5A_5A5A;
      saw_we         = 1'b0;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      repeat (12) begin
         if (bus.vrf_we || done || busy) saw_we = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_write", 32'(saw_we), 32'd0);
      chk("abort_wd4_clear", bus.vrf_wd4, 32'd0);

      run_cmd(tbl[1]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vector_load_unit.md
VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 Parameter: ELEM_BYTES, default 4, byte increment between consecutive elements when the stride feature is compiled out.
REQ-002 Reset is reset, asynchronous, active-high; the clock is clk.
REQ-003 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  load-command pulse, sampled only in IDLE.
REQ-006 Port: base_addr  input  32  byte address of element 0, sampled with start.
REQ-007 Port: vd  input  4  destination vector register number, sampled with start.
REQ-008 Port: stride  input  32  byte stride between elements, sampled with start (present only with VLOAD_STRIDE_EN).
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle pulse coincident with vrf_we.
REQ-011 Port: mem_re  output  1  memory read request, one cycle per element.
REQ-012 Port: mem_addr  output  32  read address, valid while mem_re=1.
REQ-013 Port: mem_rdata  input  32  read data, valid while mem_rvalid=1.
REQ-014 Port: mem_rvalid  input  1  read-response strobe.
REQ-015 Port: vrf_we  output  1  vector register file write enable.
REQ-016 Port: vrf_vd  output  4  destination vector number for the write.
REQ-017 Port: vrf_wd0..vrf_wd4  output  32 each  element 0..4 of the vector written.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, WRITE, encoded in registers.
REQ-019 IDLE: start=1 at a rising edge latches base_addr, vd, stride (if enabled), clears index to 0, next state REQ; start=0 stays IDLE.
REQ-020 REQ: mem_re=1 for exactly one cycle, mem_addr = base + index*step (modulo 2^32, wrap-around silent), next state WAIT.
REQ-021 WAIT: mem_re=0; on mem_rvalid=1 mem_rdata is captured into element[index]; if index=4 next state WRITE, else index+1 and next REQ; without mem_rvalid the block stays in WAIT indefinitely.
REQ-022 WRITE: vrf_we=1, done=1, vrf_vd = latched vd, vrf_wd0..4 = captured elements, for exactly one cycle; next state IDLE.
REQ-023 vrf_wd0..4 and vrf_vd SHALL hold their last values outside WRITE; vrf_we and done are 0 outside WRITE.
REQ-024 start while busy=1 SHALL be ignored; it is not queued.
REQ-025 mem_rvalid outside WAIT SHALL be ignored, with no state or element change.
REQ-026 start in the same cycle as WRITE SHALL be ignored; a new command is accepted only in IDLE in the following cycle.
REQ-027 Latency: with mem_rvalid returned in the first WAIT cycle, vrf_we is asserted in the 11th cycle after the edge that samples start.

Reset
REQ-028 On reset, the state SHALL be IDLE, index 0, all elements 0, vrf_vd 0, base/stride latches 0, busy/done/mem_re/vrf_we 0, and mem_addr 0.
REQ-029 Reset mid-operation SHALL abort immediately with no vrf_we and no done; a later mem_rvalid is ignored.

Configuration
REQ-030 With VLOAD_STRIDE_EN defined, the stride port exists and step = latched stride (32-bit, two's-complement, negative allowed).
REQ-031 Without VLOAD_STRIDE_EN, the stride port is absent and step = ELEM_BYTES.

Verification
REQ-032 Reset, idle 5 cycles -> busy=0, vrf_we=0, mem_re=0, all vrf_wd*=0.
REQ-033 start, base 0x100, vd 3, 1-cycle memory returning 0xA0..0xA4 -> addresses 0x100,0x104,0x108,0x10C,0x110; vrf_we after 11 cycles, vrf_vd=3, wd0..4=0xA0..0xA4, done single pulse.
REQ-034 VLOAD_STRIDE_EN, base 0xFFFFFFF8, stride 8 -> addresses 0xFFFFFFF8,0x0,0x8,0x10,0x18 (wrap).
REQ-035 mem_rvalid delayed 3 cycles per element -> FSM holds WAIT, exactly 5 mem_re pulses, correct vector written.
REQ-036 Second start during busy plus spurious mem_rvalid in REQ -> ignored; only one vrf_we with the first command's data.
REQ-037 reset asserted after the 3rd element is captured -> no vrf_we, state IDLE; a new start completes normally.
